sim_tl_host: RTL and testbench



---
 rtl/sim_tl_host_pkg.sv | 79 +++++++
 rtl/sim_tl_host_cmd_intg_gen.sv | 33 +++
 rtl/sim_tl_host.sv | 170 +++++++++++++++++
 tb/tb_sim_tl_host.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_tl_host_pkg.sv
// Shared types and helpers for the simulation TL-UL host: bus payloads, opcodes, field helpers.
package sim_tl_host_pkg;

   localparam int unsigned TL_AW     = 32;
   localparam int unsigned TL_DW     = 32;
   localparam int unsigned TL_AIW    = 8;
   localparam int unsigned TL_DIW    = 1;
   localparam int unsigned TL_SZW    = 2;
   localparam int unsigned TL_DBW    = TL_DW / 8;
   localparam int unsigned TL_INTG_W = 7;
   localparam int unsigned MUBI4_W   = 4;
   localparam int unsigned TL_OP_W   = 3;

   // Command integrity covers instr_type, address, opcode and mask.
   localparam int unsigned CMD_PAYLOAD_W = MUBI4_W + TL_AW + TL_OP_W + TL_DBW;

   localparam logic [MUBI4_W-1:0] MuBi4False = 4'h9;

   typedef enum logic [TL_OP_W-1:0] {
      PutFullData    = 3'h0,
      PutPartialData = 3'h1,
      Get            = 3'h4
   } tl_a_op_e;

   typedef enum logic [TL_OP_W-1:0] {
      AccessAck     = 3'h0,
      AccessAckData = 3'h1
   } tl_d_op_e;

   typedef struct packed {
      logic [MUBI4_W-1:0]   instr_type;
      logic [TL_INTG_W-1:0] cmd_intg;
      logic [TL_INTG_W-1:0] data_intg;
   } tl_a_user_t;

   typedef struct packed {
      logic                a_valid;
      tl_a_op_e            a_opcode;
      logic [2:0]          a_param;
      logic [TL_SZW-1:0]   a_size;
      logic [TL_AIW-1:0]   a_source;
      logic [TL_AW-1:0]    a_address;
      logic [TL_DBW-1:0]   a_mask;
      logic [TL_DW-1:0]    a_data;
      tl_a_user_t          a_user;
      logic                d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic                d_valid;
      tl_d_op_e            d_opcode;
      logic [2:0]          d_param;
      logic [TL_SZW-1:0]   d_size;
      logic [TL_AIW-1:0]   d_source;
      logic [TL_DIW-1:0]   d_sink;
      logic [TL_DW-1:0]    d_data;
      logic                d_error;
      logic                a_ready;
   } tl_d2h_t;

   // Reads are Get, writes with every byte enabled are PutFullData, other writes are partial.
   function automatic tl_a_op_e sel_a_op(input logic we, input logic [TL_DBW-1:0] be);
      tl_a_op_e op;
      if (!we) begin
         op = Get;
      end else if (&be) begin
         op = PutFullData;
      end else begin
         op = PutPartialData;
      end
      return op;
   endfunction

   // Transfer size code for a full-width access of the given data width.
   function automatic logic [TL_SZW-1:0] a_size_for(input int unsigned width);
      return TL_SZW'($clog2(width / 8));
   endfunction

endpackage

// File: rtl/sim_tl_host_cmd_intg_gen.sv
// Integrity generator for the A channel: Hamming-style check bits over the command and data.
module sim_tl_host_cmd_intg_gen
   import sim_tl_host_pkg::*;
(
   input  logic [CMD_PAYLOAD_W-1:0] i_cmd,
   input  logic [TL_DW-1:0]         i_data,
   output logic [TL_INTG_W-1:0]     o_cmd_intg_c,
   output logic [TL_INTG_W-1:0]     o_data_intg_c
);

   localparam int unsigned ProtW = 64;

   // Check bit j is the parity of every payload bit whose 1-based position has bit j set.
   function automatic logic [TL_INTG_W-1:0] check_bits(input logic [ProtW-1:0] d);
      logic [TL_INTG_W-1:0] c;
      c = '0;
      for (int j = 0; j < TL_INTG_W; j++) begin
         for (int i = 0; i < ProtW; i++) begin
            if ((((i + 1) >> j) & 1) != 0) begin
               c[j] = c[j] ^ d[i];
            end
         end
      end
      return c;
   endfunction

   // Both codes are pure functions of the held A-channel fields.
   always_comb begin
      o_cmd_intg_c  = check_bits(ProtW'(i_cmd));
      o_data_intg_c = check_bits(ProtW'(i_data));
   end

endmodule

// File: rtl/sim_tl_host.sv
// Simulation-only TL-UL host: request/grant commands in, TL-UL A beats out, D responses as pulses.
module sim_tl_host
   import sim_tl_host_pkg::*;
#(
   parameter int unsigned AddrWidth      = 32,
   parameter int unsigned Width          = 32,
   parameter int unsigned MaxOutstanding = 2,
   parameter int unsigned SourceBase     = 0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_i,
   output logic                 gnt_o,
   input  logic                 we_i,
   input  logic [AddrWidth-1:0] addr_i,
   input  logic [Width-1:0]     wdata_i,
   input  logic [Width/8-1:0]   be_i,
   output logic                 rvalid_o,
   output logic [Width-1:0]     rdata_o,
   output logic                 err_o,
   output logic                 idle_o,
   output logic                 unexpected_o,
   output tl_h2d_t              tl_o,
   input  tl_d2h_t              tl_i
);

`ifdef SYNTHESIS
   // Deliberately unresolvable: this host only exists for simulation harnesses.
   sim_tl_host_is_simulation_only u_sim_only_guard ();
`endif

   localparam int unsigned SizeW = $clog2(Width / 8);
   localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);
   localparam int unsigned SrcW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

   // A-channel holding register
   logic                 r_a_valid;
   tl_a_op_e             r_a_op;
   logic [TL_AW-1:0]     r_a_addr;
   logic [TL_DBW-1:0]    r_a_mask;
   logic [TL_DW-1:0]     r_a_data;
   logic [TL_AIW-1:0]    r_a_source;

   // Bookkeeping and response registers
   logic [SrcW-1:0]      r_src;
   logic [CntW-1:0]      r_cnt;
   logic                 r_rvalid;
   logic [Width-1:0]     r_rdata;
   logic                 r_err;
   logic                 r_unexpected;

   logic                 w_gnt;
   logic                 w_accept;
   logic                 w_a_hs;
   logic                 w_d_hs;
   logic [TL_AW-1:0]     w_word_addr;
   logic [TL_DBW-1:0]    w_be;
   logic [TL_INTG_W-1:0] w_cmd_intg;
   logic [TL_INTG_W-1:0] w_data_intg;
   logic                 w_unused;

   assign w_gnt    = !rst_i && !r_a_valid && (r_cnt < CntW'(MaxOutstanding));
   assign w_accept = req_i && w_gnt;
   assign w_a_hs   = r_a_valid && tl_i.a_ready;
   assign w_d_hs   = tl_i.d_valid;

   assign w_word_addr = TL_AW'({addr_i[AddrWidth-1:SizeW], {SizeW{1'b0}}});
   assign w_be        = TL_DBW'(be_i);

   // Fields of the D channel this host has no use for, plus the ignored sub-word address bits.
   assign w_unused = ^{tl_i.d_param, tl_i.d_size, tl_i.d_source, tl_i.d_sink, addr_i[SizeW-1:0]};

   assign gnt_o        = w_gnt;
   assign idle_o       = !r_a_valid && (r_cnt == '0);
   assign rvalid_o     = r_rvalid;
   assign rdata_o      = r_rdata;
   assign err_o        = r_err;
   assign unexpected_o = r_unexpected;

   // Load the A beat on accept and drop it once the device takes it; fields stay frozen in between.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_a_valid  <= 1'b0;
         r_a_op     <= Get;
         r_a_addr   <= '0;
         r_a_mask   <= '0;
         r_a_data   <= '0;
         r_a_source <= '0;
         r_src      <= '0;
      end else if (w_accept) begin
         r_a_valid  <= 1'b1;
         r_a_op     <= sel_a_op(we_i, w_be);
         r_a_addr   <= w_word_addr;
         r_a_mask   <= we_i ? w_be : '1;
         r_a_data   <= we_i ? TL_DW'(wdata_i) : '0;
         r_a_source <= TL_AIW'(SourceBase) + TL_AIW'(r_src);
         r_src      <= (r_src == SrcW'(MaxOutstanding - 1)) ? '0 : r_src + SrcW'(1);
      end else if (w_a_hs) begin
         r_a_valid  <= 1'b0;
      end
   end

   // In-flight count: up on A handshake, down on D handshake, floored at zero.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt        <= '0;
         r_unexpected <= 1'b0;
      end else begin
         case ({w_a_hs, w_d_hs})
            2'b10:   r_cnt <= r_cnt + CntW'(1);
            2'b01:   if (r_cnt != '0) r_cnt <= r_cnt - CntW'(1);
            default: r_cnt <= r_cnt;
         endcase
         if (w_d_hs && (r_cnt == '0)) begin
            r_unexpected <= 1'b1;
         end
      end
   end

   // One-cycle response pulse; data and error hold between pulses.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_err    <= 1'b0;
      end else begin
         r_rvalid <= w_d_hs;
         if (w_d_hs) begin
            r_rdata <= (tl_i.d_opcode == AccessAckData) ? Width'(tl_i.d_data) : '0;
            r_err   <= tl_i.d_error;
         end
      end
   end

   sim_tl_host_cmd_intg_gen u_intg_gen (
      .i_cmd         ({MuBi4False, r_a_addr, r_a_op, r_a_mask}),
      .i_data        (r_a_data),
      .o_cmd_intg_c  (w_cmd_intg),
      .o_data_intg_c (w_data_intg)
   );

   // Drive the host-to-device bundle from the holding register; D is always accepted.
   always_comb begin
      tl_o                      = '0;
      tl_o.a_valid              = r_a_valid;
      tl_o.a_opcode             = r_a_op;
      tl_o.a_param              = '0;
      tl_o.a_size               = a_size_for(Width);
      tl_o.a_source             = r_a_source;
      tl_o.a_address            = r_a_addr;
      tl_o.a_mask               = r_a_mask;
      tl_o.a_data               = r_a_data;
      tl_o.a_user.instr_type    = MuBi4False;
      tl_o.a_user.cmd_intg      = w_cmd_intg;
      tl_o.a_user.data_intg     = w_data_intg;
      tl_o.d_ready              = 1'b1;
   end

   logic [TL_OP_W+TL_AW+TL_DBW+TL_DW+TL_AIW-1:0] w_a_fields;
   assign w_a_fields = {r_a_op, r_a_addr, r_a_mask, r_a_data, r_a_source};

   a_fields_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (r_a_valid && !tl_i.a_ready) |=> $stable(w_a_fields));

   cfg_legal: assert property (@(posedge clk_i)
      (MaxOutstanding >= 1) && (MaxOutstanding <= 16) &&
      (SourceBase + MaxOutstanding <= (1 << TL_AIW)) &&
      (AddrWidth <= TL_AW) && (Width == TL_DW));

endmodule

// File: tb/tb_sim_tl_host.sv
// Bench for sim_tl_host: SRAM-like responder, transaction-level model and per-cycle compare.
`timescale 1ns/1ps
module tb_sim_tl_host;
   import sim_tl_host_pkg::*;

   localparam int unsigned MaxOut  = 2;
   localparam int unsigned SrcBase = 0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  be = '0;
   logic        gnt, rvalid, err, idle, unexp;
   logic [31:0] rdata;
   tl_h2d_t     tl_h2d;
   tl_d2h_t     tl_d2h;

   int total = 0;
   int bad   = 0;

   sim_tl_host #(.AddrWidth(32), .Width(32), .MaxOutstanding(MaxOut), .SourceBase(SrcBase)) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .we_i(we), .addr_i(addr),
      .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
      .idle_o(idle), .unexpected_o(unexp), .tl_o(tl_h2d), .tl_i(tl_d2h)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Check bits as the XOR of the 1-based positions of all set payload bits.
   function automatic logic [6:0] ref_intg(input logic [63:0] d);
      logic [6:0] s;
      s = '0;
      for (int i = 0; i < 64; i++) if (d[i]) s ^= 7'(i + 1);
      return s;
   endfunction

   // ---------------- transaction-level model ----------------
   typedef struct {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [3:0]  mask;
      logic [31:0] data;
      logic [7:0]  src;
   } beat_t;

   beat_t       m_a[$];
   int          m_out = 0;
   int          m_src = 0;
   logic        m_rvalid = 0;
   logic [31:0] m_rdata = '0;
   logic        m_err = 0;
   logic        m_unexp = 0;

   function automatic bit m_gnt();
      return (m_a.size() == 0) && (m_out < MaxOut);
   endfunction

   initial forever begin
      bit    acc, ahs, dhs;
      beat_t b;
      @(posedge clk or posedge rst);
      if (rst) begin
         m_a.delete();
         m_out = 0; m_src = 0; m_rvalid = 0; m_rdata = '0; m_err = 0; m_unexp = 0;
      end else begin
         acc = req && m_gnt();
         ahs = (m_a.size() != 0) && tl_d2h.a_ready;
         dhs = tl_d2h.d_valid;
         m_rvalid = dhs;
         if (dhs) begin
            m_rdata = (tl_d2h.d_opcode == AccessAckData) ? tl_d2h.d_data : 32'h0;
            m_err   = tl_d2h.d_error;
            if (m_out == 0) m_unexp = 1;
         end
         if (ahs && !dhs) m_out = m_out + 1;
         else if (dhs && !ahs && m_out > 0) m_out = m_out - 1;
         if (ahs) void'(m_a.pop_front());
         if (acc) begin
            b.op   = !we ? 3'h4 : ((be == 4'hF) ? 3'h0 : 3'h1);
            b.addr = {addr[31:2], 2'b00};
            b.mask = we ? be : 4'hF;
            b.data = we ? wdata : 32'h0;
            b.src  = 8'(SrcBase + m_src);
            m_a.push_back(b);
            m_src = (m_src + 1) % MaxOut;
         end
      end
   end

   // Compare every DUT output against the model just after each active edge.
   initial forever begin
      @(posedge clk);
      #1;
      check("gnt", gnt, !rst && m_gnt());
      check("a_valid", tl_h2d.a_valid, m_a.size() != 0);
      if (m_a.size() != 0) begin
         check("a_opcode", tl_h2d.a_opcode, m_a[0].op);
         check("a_address", tl_h2d.a_address, m_a[0].addr);
         check("a_mask", tl_h2d.a_mask, m_a[0].mask);
         check("a_data", tl_h2d.a_data, m_a[0].data);
         check("a_source", tl_h2d.a_source, m_a[0].src);
         check("a_size", tl_h2d.a_size, 2);
         check("a_param", tl_h2d.a_param, 0);
         check("instr_type", tl_h2d.a_user.instr_type, 4'h9);
         check("data_intg", tl_h2d.a_user.data_intg, ref_intg(64'(m_a[0].data)));
         check("cmd_intg", tl_h2d.a_user.cmd_intg,
               ref_intg(64'({4'h9, m_a[0].addr, m_a[0].op, m_a[0].mask})));
      end
      check("d_ready", tl_h2d.d_ready, 1);
      check("rvalid", rvalid, m_rvalid);
      check("rdata", rdata, m_rdata);
      check("err", err, m_err);
      check("idle", idle, (m_a.size() == 0) && (m_out == 0));
      check("unexpected", unexp, m_unexp);
   end

   // ---------------- SRAM-like responder ----------------
   typedef struct {
      tl_d_op_e    op;
      logic [31:0] data;
      logic [7:0]  src;
      logic        err;
   } rsp_t;

   rsp_t        rq[$];
   logic [31:0] mem [logic [31:0]];
   bit          rsp_a_ready = 1;
   bit          rsp_d_en    = 1;
   bit          rsp_err     = 0;
   bit          rsp_inject  = 0;
   bit          drove_q     = 0;

   initial begin
      rsp_t        r;
      logic [31:0] old;
      tl_d2h = '0;
      tl_d2h.a_ready = 1'b1;
      forever begin
         @(posedge clk);
         if (rst) begin
            rq.delete();
            drove_q = 0;
         end else begin
            if (tl_d2h.d_valid && drove_q) void'(rq.pop_front());
            if (tl_h2d.a_valid && tl_d2h.a_ready) begin
               old = mem.exists(tl_h2d.a_address) ? mem[tl_h2d.a_address] : 32'h0;
               r.src = tl_h2d.a_source;
               r.err = rsp_err;
               if (tl_h2d.a_opcode == Get) begin
                  r.op = AccessAckData;
                  r.data = old;
               end else begin
                  for (int k = 0; k < 4; k++)
                     if (tl_h2d.a_mask[k]) old[8*k +: 8] = tl_h2d.a_data[8*k +: 8];
                  mem[tl_h2d.a_address] = old;
                  r.op = AccessAck;
                  r.data = 32'h0;
               end
               rq.push_back(r);
            end
         end
         #2;
         tl_d2h.d_valid = 1'b0;
         tl_d2h.a_ready = rsp_a_ready;
         drove_q = 0;
         if (!rst) begin
            if (rsp_inject) begin
               tl_d2h.d_valid  = 1'b1;
               tl_d2h.d_opcode = AccessAck;
               tl_d2h.d_data   = 32'hBADBAD00;
               tl_d2h.d_error  = 1'b0;
               tl_d2h.d_source = 8'h0;
               rsp_inject = 0;
            end else if (rsp_d_en && rq.size() != 0) begin
               tl_d2h.d_valid  = 1'b1;
               tl_d2h.d_opcode = rq[0].op;
               tl_d2h.d_data   = rq[0].data;
               tl_d2h.d_error  = rq[0].err;
               tl_d2h.d_source = rq[0].src;
               drove_q = 1;
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
      int n;
      n = 0;
      req = 1'b1; we = w; addr = a; wdata = d; be = b;
      while (!gnt && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("gnt_wait", n < 50, 1);
      @(negedge clk);
      req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
   endtask

   task automatic wait_rsp(output logic [31:0] d, output logic e);
      int n;
      n = 0;
      while (!rvalid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("rsp_wait", n < 50, 1);
      d = rdata;
      e = err;
      @(negedge clk);
   endtask

   task automatic wait_a_taken();
      int n;
      n = 0;
      while (tl_h2d.a_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("a_taken_wait", n < 50, 1);
   endtask

   initial begin
      logic [31:0] d;
      logic        e;

      repeat (3) begin
         @(negedge clk);
         check("gnt_in_reset", gnt, 0);
      end
      rst = 1'b0;
      #1;
      check("rst_a_valid", tl_h2d.a_valid, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_rdata", rdata, 0);
      check("rst_err", err, 0);
      check("rst_idle", idle, 1);
      check("rst_unexp", unexp, 0);
      @(negedge clk);

      // Full write
      issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      check("w1_valid", tl_h2d.a_valid, 1);
      check("w1_op", tl_h2d.a_opcode, 3'h0);
      check("w1_mask", tl_h2d.a_mask, 4'hF);
      check("w1_addr", tl_h2d.a_address, 32'h10);
      check("w1_data", tl_h2d.a_data, 32'hDEADBEEF);
      check("w1_src", tl_h2d.a_source, 0);
      wait_rsp(d, e);
      check("w1_err", e, 0);
      check("w1_rdata", d, 0);

      // Write then read back
      issue(1'b1, 32'h8, 32'h12345678, 4'hF);
      wait_rsp(d, e);
      issue(1'b0, 32'h8, 32'h0, 4'h0);
      wait_rsp(d, e);
      check("rd8_data", d, 32'h12345678);
      check("rd8_err", e, 0);

      // Partial write, unaligned read
      issue(1'b1, 32'h20, 32'hAABBCCDD, 4'h3);
      check("pw_op", tl_h2d.a_opcode, 3'h1);
      check("pw_mask", tl_h2d.a_mask, 4'h3);
      wait_rsp(d, e);
      issue(1'b0, 32'h13, 32'hFFFFFFFF, 4'h0);
      check("rd13_addr", tl_h2d.a_address, 32'h10);
      check("rd13_mask", tl_h2d.a_mask, 4'hF);
      check("rd13_op", tl_h2d.a_opcode, 3'h4);
      check("rd13_data", tl_h2d.a_data, 0);
      check("rd13_src", tl_h2d.a_source, 0);
      wait_rsp(d, e);
      check("rd13_rdata", d, 32'hDEADBEEF);
      issue(1'b0, 32'h20, 32'h0, 4'h0);
      check("rd20_src", tl_h2d.a_source, 1);
      wait_rsp(d, e);
      check("rd20_rdata", d, 32'h0000CCDD);

      // Backpressure on A, then D withheld with two in flight
      rsp_a_ready = 0;
      rsp_d_en = 0;
      repeat (2) @(negedge clk);
      issue(1'b1, 32'h30, 32'h30303030, 4'hF);
      repeat (5) begin
         check("bp_valid", tl_h2d.a_valid, 1);
         check("bp_addr", tl_h2d.a_address, 32'h30);
         check("bp_gnt", gnt, 0);
         @(negedge clk);
      end
      rsp_a_ready = 1;
      wait_a_taken();
      issue(1'b1, 32'h34, 32'h34343434, 4'hF);
      wait_a_taken();
      repeat (4) begin
         check("full_gnt", gnt, 0);
         check("full_idle", idle, 0);
         @(negedge clk);
      end
      rsp_d_en = 1;
      wait_rsp(d, e);
      check("b2b_rvalid", rvalid, 1);
      @(negedge clk);
      check("drain_gnt", gnt, 1);

      // Error response and hold
      rsp_err = 1;
      issue(1'b0, 32'h8, 32'h0, 4'h0);
      wait_rsp(d, e);
      rsp_err = 0;
      check("err_flag", e, 1);
      check("err_rdata", d, 32'h12345678);
      @(negedge clk);
      check("err_hold", err, 1);

      // Response with nothing outstanding
      check("pre_inj_idle", idle, 1);
      rsp_inject = 1;
      repeat (3) @(negedge clk);
      check("inj_unexp", unexp, 1);
      check("inj_idle", idle, 1);
      check("inj_gnt", gnt, 1);
      check("inj_rdata", rdata, 0);

      // Reset with two in flight
      rsp_d_en = 0;
      issue(1'b1, 32'h40, 32'h40404040, 4'hF);
      issue(1'b1, 32'h44, 32'h44444444, 4'hF);
      wait_a_taken();
      check("inflight_idle", idle, 0);
      rst = 1'b1;
      #1;
      check("mid_rst_a_valid", tl_h2d.a_valid, 0);
      check("mid_rst_idle", idle, 1);
      check("mid_rst_rvalid", rvalid, 0);
      check("mid_rst_unexp", unexp, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      rsp_d_en = 1;
      repeat (4) begin
         @(negedge clk);
         check("post_rst_rvalid", rvalid, 0);
      end
      issue(1'b0, 32'h10, 32'h0, 4'h0);
      check("post_rst_src", tl_h2d.a_source, 0);
      wait_rsp(d, e);
      check("post_rst_rdata", d, 32'hDEADBEEF);
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
